// File: rtl/mux_4a1_sincronico.sv
// Time-multiplexes four 8-bit lanes onto one lane, running on clk_4f.
// Lanes 1..3 are held from the cnt==0 sample edge; lane 0 passes straight through on that edge.
module mux_4a1_sincronico #(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk_4f,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] data_0,
  input  logic [BUS_WIDTH-1:0] data_1,
  input  logic [BUS_WIDTH-1:0] data_2,
  input  logic [BUS_WIDTH-1:0] data_3,
  input  logic                 valid_0,
  input  logic                 valid_1,
  input  logic                 valid_2,
  input  logic                 valid_3,
  output logic [BUS_WIDTH-1:0] data_out,
  output logic                 valid_out,
  output logic [1:0]           lane_sel
);

  logic [1:0]           r_cnt;
  logic [BUS_WIDTH-1:0] r_hold_d1;
  logic [BUS_WIDTH-1:0] r_hold_d2;
  logic [BUS_WIDTH-1:0] r_hold_d3;
  logic                 r_hold_v1;
  logic                 r_hold_v2;
  logic                 r_hold_v3;

  logic [BUS_WIDTH-1:0] w_lane_d;
  logic                 w_lane_v;
  logic [BUS_WIDTH-1:0] w_next_d;

  // Select the lane for the current phase; invalid lanes are forced to zero.
  always_comb begin
    w_lane_d = '0;
    w_lane_v = 1'b0;
    case (r_cnt)
      2'd0: begin
        w_lane_d = data_0;
        w_lane_v = valid_0;
      end
      2'd1: begin
        w_lane_d = r_hold_d1;
        w_lane_v = r_hold_v1;
      end
      2'd2: begin
        w_lane_d = r_hold_d2;
        w_lane_v = r_hold_v2;
      end
      2'd3: begin
        w_lane_d = r_hold_d3;
        w_lane_v = r_hold_v3;
      end
      default: begin
        w_lane_d = '0;
        w_lane_v = 1'b0;
      end
    endcase
    if (w_lane_v) begin
      w_next_d = w_lane_d;
    end else begin
      w_next_d = '0;
    end
  end

  // Phase counter, lane sampling and registered outputs.
  always_ff @(posedge clk_4f) begin
    if (!reset) begin
      r_cnt     <= 2'd0;
      r_hold_d1 <= '0;
      r_hold_d2 <= '0;
      r_hold_d3 <= '0;
      r_hold_v1 <= 1'b0;
      r_hold_v2 <= 1'b0;
      r_hold_v3 <= 1'b0;
      data_out  <= '0;
      valid_out <= 1'b0;
      lane_sel  <= 2'd0;
    end else begin
      r_cnt <= r_cnt + 2'd1;
      if (r_cnt == 2'd0) begin
        r_hold_d1 <= data_1;
        r_hold_d2 <= data_2;
        r_hold_d3 <= data_3;
        r_hold_v1 <= valid_1;
        r_hold_v2 <= valid_2;
        r_hold_v3 <= valid_3;
      end else begin
        r_hold_d1 <= r_hold_d1;
        r_hold_d2 <= r_hold_d2;
        r_hold_d3 <= r_hold_d3;
        r_hold_v1 <= r_hold_v1;
        r_hold_v2 <= r_hold_v2;
        r_hold_v3 <= r_hold_v3;
      end
      data_out  <= w_next_d;
      valid_out <= w_lane_v;
      lane_sel  <= r_cnt;
    end
  end

endmodule
